// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       func;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             flag_c;
  logic             flag_z;
  logic             flag_err;

  modport master (
    output in_valid, in1, in2, func, out_ready,
    input  in_ready, out_valid, out, out_hi, flag_c, flag_z, flag_err
  );

  modport slave (
    input  in_valid, in1, in2, func, out_ready,
    output in_ready, out_valid, out, out_hi, flag_c, flag_z, flag_err
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with iterative shift-add multiply and multi-bit shifts
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_PASS = 4'd2;
  localparam logic [3:0] OP_SHL1 = 4'd3;
  localparam logic [3:0] OP_SHR1 = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_SHLN = 4'd10;
  localparam logic [3:0] OP_SHRN = 4'd11;
  localparam logic [SHW-1:0] CNT_MAX = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q, mcand_q, hi_q;
  logic [SHW-1:0]   cnt_q, n_q, last_cnt;
  logic [WIDTH-1:0] out_q, out_hi_q;
  logic             flag_c_q, flag_z_q, flag_err_q;

  logic             accept, last_step, multi;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_c, res_err;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt, sh_nxt;
  logic             sh_c;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;
  assign bus.out_hi    = out_hi_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_err  = flag_err_q;

  // Shifts by zero collapse to a single-cycle pass-through.
  assign multi = (bus.func == OP_MUL) ||
                 (((bus.func == OP_SHLN) || (bus.func == OP_SHRN)) && (bus.in2[SHW-1:0] != '0));
  assign last_cnt = (op_q == OP_MUL) ? CNT_MAX : (n_q - SHW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        accept    = 1'b1;
        state_nxt = multi ? BUSY : DONE;
      end
      BUSY: begin
        last_step = (cnt_q == last_cnt);
        if (last_step) state_nxt = DONE;
      end
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum     = '0;
    res     = '0;
    res_c   = 1'b0;
    res_err = 1'b0;
    case (bus.func)
      OP_ADD:  begin sum = {1'b0, bus.in1} + {1'b0, bus.in2}; res = sum[WIDTH-1:0]; res_c = sum[WIDTH]; end
      OP_SUB:  begin sum = {1'b0, bus.in1} - {1'b0, bus.in2}; res = sum[WIDTH-1:0]; res_c = sum[WIDTH]; end
      OP_PASS: res = bus.in1;
      OP_SHL1: begin res = bus.in1 << 1; res_c = bus.in1[WIDTH-1]; end
      OP_SHR1: begin res = bus.in1 >> 1; res_c = bus.in1[0]; end
      OP_AND:  res = bus.in1 & bus.in2;
      OP_NOT:  res = ~bus.in1;
      OP_OR:   res = bus.in1 | bus.in2;
      OP_XOR:  res = bus.in1 ^ bus.in2;
      OP_MUL, OP_SHLN, OP_SHRN: res = bus.in1;
      default: res_err = 1'b1;
    endcase
  end

  // Multiply keeps the multiplier in work_q and shifts product bits in from the top.
  always_comb begin
    mul_sum    = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
    mul_hi_nxt = mul_sum[WIDTH:1];
    mul_lo_nxt = {mul_sum[0], work_q[WIDTH-1:1]};
    sh_nxt     = (op_q == OP_SHLN) ? (work_q << 1) : (work_q >> 1);
    sh_c       = (op_q == OP_SHLN) ? work_q[WIDTH-1] : work_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      work_q     <= '0;
      mcand_q    <= '0;
      hi_q       <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
      out_q      <= '0;
      out_hi_q   <= '0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_err_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.func;
        cnt_q   <= '0;
        n_q     <= bus.in2[SHW-1:0];
        work_q  <= (bus.func == OP_MUL) ? bus.in2 : bus.in1;
        mcand_q <= bus.in1;
        hi_q    <= '0;
        if (!multi) begin
          out_q      <= res;
          out_hi_q   <= '0;
          flag_c_q   <= res_c;
          flag_z_q   <= (res == '0);
          flag_err_q <= res_err;
        end
      end
      if (state == BUSY) begin
        cnt_q <= cnt_q + SHW'(1);
        if (op_q == OP_MUL) begin
          hi_q   <= mul_hi_nxt;
          work_q <= mul_lo_nxt;
        end else begin
          work_q <= sh_nxt;
        end
        if (last_step) begin
          flag_err_q <= 1'b0;
          if (op_q == OP_MUL) begin
            out_q    <= mul_lo_nxt;
            out_hi_q <= mul_hi_nxt;
            flag_c_q <= (mul_hi_nxt != '0);
            flag_z_q <= (mul_lo_nxt == '0);
          end else begin
            out_q    <= sh_nxt;
            out_hi_q <= '0;
            flag_c_q <= sh_c;
            flag_z_q <= (sh_nxt == '0);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed self-checking bench for alu_seq
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic       pend = 1'b0;
  logic [3:0] pf;
  logic [7:0] pa, pb;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_op(input logic [3:0] f, input int a, input int b,
                        output int r, output int hi, output int c, output int z,
                        output int err, output int lat);
    int n;
    int p;
    n = b % 8;
    r = 0; hi = 0; c = 0; err = 0; lat = 0;
    case (f)
      0: begin r = (a + b) % 256; c = (a + b) / 256; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: r = a;
      3: begin r = (a * 2) % 256; c = a / 128; end
      4: begin r = a / 2; c = a % 2; end
      5: r = a & b;
      6: r = 255 - a;
      7: r = a | b;
      8: r = a ^ b;
      9: begin p = a * b; r = p % 256; hi = p / 256; c = (hi != 0) ? 1 : 0; lat = 8; end
      10: begin r = (a * (1 << n)) % 256; c = (n == 0) ? 0 : (a >> (8 - n)) % 2; lat = n; end
      11: begin r = a >> n; c = (n == 0) ? 0 : (a >> (n - 1)) % 2; lat = n; end
      default: err = 1;
    endcase
    z = (r == 0) ? 1 : 0;
  endtask

  task automatic do_op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b, input int hold);
    int r, hi, c, z, err, lat;
    int k;
    ref_op(f, a, b, r, hi, c, z, err, lat);
    bus.in_valid  = 1'b1;
    bus.func      = f;
    bus.in1       = a;
    bus.in2       = b;
    bus.out_ready = (hold == 0);
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check_val("wait_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    if (pend) begin
      bus.func = pf; bus.in1 = pa; bus.in2 = pb;
    end else begin
      bus.in_valid = 1'b0;
    end
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(posedge clk); #1; k++;
    end
    check_val($sformatf("latency f=%0d", f), k, lat);
    for (int i = 0; i < hold; i++) begin
      check_val("hold_out", bus.out, r);
      check_val("hold_in_ready", bus.in_ready, 1'b0);
      check_val("hold_out_valid", bus.out_valid, 1'b1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    check_val($sformatf("out f=%0d a=%0h b=%0h", f, a, b), bus.out, r);
    check_val($sformatf("out_hi f=%0d", f), bus.out_hi, hi);
    check_val($sformatf("flag_c f=%0d a=%0h b=%0h", f, a, b), bus.flag_c, c);
    check_val($sformatf("flag_z f=%0d", f), bus.flag_z, z);
    check_val($sformatf("flag_err f=%0d", f), bus.flag_err, err);
    @(posedge clk); #1;
    check_val("out_valid_drop", bus.out_valid, 1'b0);
    check_val("out_kept", bus.out, r);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.func      = '0;
    bus.out_ready = 1'b0;
    pf = '0; pa = '0; pb = '0;
    #1;
    check_val("rst_out_valid", bus.out_valid, 1'b0);
    check_val("rst_out", bus.out, 8'd0);
    check_val("rst_flags", {bus.out_hi, bus.flag_c, bus.flag_z, bus.flag_err}, 11'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_in_ready", bus.in_ready, 1'b1);

    do_op(4'd0, 8'd200, 8'd100, 0);
    do_op(4'd1, 8'd5, 8'd10, 0);
    do_op(4'd1, 8'd7, 8'd7, 0);
    do_op(4'd9, 8'd200, 8'd200, 0);
    do_op(4'd9, 8'd15, 8'd17, 0);
    do_op(4'd10, 8'h81, 8'd3, 0);
    do_op(4'd11, 8'h81, 8'd1, 0);
    do_op(4'd10, 8'h81, 8'd8, 0);

    pend = 1'b1; pf = 4'd0; pa = 8'd5; pb = 8'd6;
    do_op(4'd0, 8'd1, 8'd2, 5);
    check_val("held_in_ready", bus.in_ready, 1'b1);
    pend = 1'b0;
    do_op(4'd0, 8'd5, 8'd6, 0);

    bus.in_valid = 1'b1; bus.func = 4'd9; bus.in1 = 8'd200; bus.in2 = 8'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", bus.out_valid, 1'b0);
    check_val("abort_out", bus.out, 8'd0);
    check_val("abort_out_hi", bus.out_hi, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("abort_in_ready", bus.in_ready, 1'b1);
    do_op(4'd0, 8'd1, 8'd1, 0);

    do_op(4'd15, 8'hFF, 8'h00, 0);
    do_op(4'd8, 8'hF0, 8'hFF, 0);

    for (int i = 0; i < 150; i++) begin
      do_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
